// File: rtl/cms_pix_28_package.sv
// Shared types and constants for the CMS pixel-28 configuration-chain emulator.
package cms_pix_28_package;

  localparam int unsigned CFG_BITS_DEFAULT = 64;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StShifting = 2'd1,
    StLoading  = 2'd2,
    StHold     = 2'd3
  } cfg_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cms_pix_28_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset.
module cms_pix_28_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cms_pix_28_dut_cfg_emu.sv
// Emulates the pixel DUT's two serial configuration chains: oversampled shift clock,
// parallel load into latched registers, length checking and a DUT-side hold reset.
module cms_pix_28_dut_cfg_emu
  import cms_pix_28_package::*;
#(
  parameter int unsigned CFG_BITS = CFG_BITS_DEFAULT
) (
  input  logic                fw_clk,
  input  logic                fw_rst,
  input  logic                fw_super_pixel_sel,
  input  logic                fw_config_clk,
  input  logic                fw_reset_not,
  input  logic                fw_config_in,
  input  logic                fw_config_load,
  output logic                fw_config_out,
  output logic [CFG_BITS-1:0] cfg_q_0,
  output logic [CFG_BITS-1:0] cfg_q_1,
  output logic [15:0]         shift_cnt,
  output logic                load_strobe,
  output logic                len_err
);

  localparam logic [15:0] LP_CFG_LEN = 16'(CFG_BITS);

  logic w_sel_s;
  logic w_cclk_s;
  logic w_rstn_s;
  logic w_din_s;
  logic w_load_s;

  cms_pix_28_sync2 u_sync_sel (
    .i_clk (fw_clk),
    .i_rst (fw_rst),
    .i_d   (fw_super_pixel_sel),
    .o_q   (w_sel_s)
  );

  cms_pix_28_sync2 u_sync_cclk (
    .i_clk (fw_clk),
    .i_rst (fw_rst),
    .i_d   (fw_config_clk),
    .o_q   (w_cclk_s)
  );

  cms_pix_28_sync2 u_sync_rstn (
    .i_clk (fw_clk),
    .i_rst (fw_rst),
    .i_d   (fw_reset_not),
    .o_q   (w_rstn_s)
  );

  cms_pix_28_sync2 u_sync_din (
    .i_clk (fw_clk),
    .i_rst (fw_rst),
    .i_d   (fw_config_in),
    .o_q   (w_din_s)
  );

  cms_pix_28_sync2 u_sync_load (
    .i_clk (fw_clk),
    .i_rst (fw_rst),
    .i_d   (fw_config_load),
    .o_q   (w_load_s)
  );

  cfg_state_e          r_state;
  cfg_state_e          w_state_d;
  logic [1:0]          r_arm_cnt;
  logic                r_cclk_prev;
  logic                r_load_prev;
  logic                r_sel_prev;
  logic [CFG_BITS-1:0] r_chain_0;
  logic [CFG_BITS-1:0] r_chain_1;
  logic [CFG_BITS-1:0] r_cfg_q_0;
  logic [CFG_BITS-1:0] r_cfg_q_1;
  logic [15:0]         r_shift_cnt;
  logic                r_len_err;
  logic                r_cfg_out;

  logic [CFG_BITS-1:0] w_chain_0_d;
  logic [CFG_BITS-1:0] w_chain_1_d;
  logic [CFG_BITS-1:0] w_cfg_q_0_d;
  logic [CFG_BITS-1:0] w_cfg_q_1_d;
  logic [15:0]         w_shift_cnt_d;
  logic [15:0]         w_cnt_shifted;
  logic                w_len_err_d;

  logic w_armed;
  logic w_hold;
  logic w_shift;
  logic w_load;
  logic w_sel_chg;

  // The previous-value registers need one cycle behind the filled synchronizers before an
  // edge can be trusted; otherwise a line already high at reset release looks like a rise.
  assign w_armed   = (r_arm_cnt == 2'd3);
  assign w_hold    = (r_state == StHold) || !w_rstn_s;
  assign w_shift   = w_armed && !w_hold && w_cclk_s && !r_cclk_prev;
  assign w_load    = w_armed && !w_hold && w_load_s && !r_load_prev;
  assign w_sel_chg = w_armed && !w_hold && (w_sel_s != r_sel_prev);

  always_comb begin
    w_chain_0_d   = r_chain_0;
    w_chain_1_d   = r_chain_1;
    w_cfg_q_0_d   = r_cfg_q_0;
    w_cfg_q_1_d   = r_cfg_q_1;
    w_cnt_shifted = r_shift_cnt;
    w_shift_cnt_d = r_shift_cnt;
    w_len_err_d   = r_len_err;
    if (w_hold) begin
      w_chain_0_d   = '0;
      w_chain_1_d   = '0;
      w_cfg_q_0_d   = '0;
      w_cfg_q_1_d   = '0;
      w_shift_cnt_d = '0;
      w_len_err_d   = 1'b0;
    end else begin
      if (w_shift) begin
        if (w_sel_s) begin
          w_chain_1_d = {r_chain_1[CFG_BITS-2:0], w_din_s};
        end else begin
          w_chain_0_d = {r_chain_0[CFG_BITS-2:0], w_din_s};
        end
        w_cnt_shifted = sat_inc16(r_shift_cnt);
      end
      w_shift_cnt_d = w_cnt_shifted;
      // A coincident shift is already folded into the chain and count seen by the load.
      if (w_load) begin
        if (w_sel_s) begin
          w_cfg_q_1_d = w_chain_1_d;
        end else begin
          w_cfg_q_0_d = w_chain_0_d;
        end
        if (w_cnt_shifted != LP_CFG_LEN) begin
          w_len_err_d = 1'b1;
        end
        w_shift_cnt_d = '0;
      end else if (w_sel_chg) begin
        if ((w_cnt_shifted != 16'd0) && (w_cnt_shifted != LP_CFG_LEN)) begin
          w_len_err_d = 1'b1;
        end
        w_shift_cnt_d = '0;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_load) begin
          w_state_d = StLoading;
        end else if (w_shift) begin
          w_state_d = StShifting;
        end
      end
      StShifting: begin
        if (w_load) begin
          w_state_d = StLoading;
        end
      end
      StLoading: begin
        w_state_d = w_shift ? StShifting : StIdle;
      end
      StHold: begin
        if (w_rstn_s) begin
          w_state_d = StIdle;
        end
      end
    endcase
    if (!w_rstn_s) begin
      w_state_d = StHold;
    end
  end

  always_ff @(posedge fw_clk or posedge fw_rst) begin
    if (fw_rst) begin
      r_state     <= StIdle;
      r_arm_cnt   <= 2'd0;
      r_cclk_prev <= 1'b0;
      r_load_prev <= 1'b0;
      r_sel_prev  <= 1'b0;
      r_chain_0   <= '0;
      r_chain_1   <= '0;
      r_cfg_q_0   <= '0;
      r_cfg_q_1   <= '0;
      r_shift_cnt <= '0;
      r_len_err   <= 1'b0;
      r_cfg_out   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      if (r_arm_cnt != 2'd3) begin
        r_arm_cnt <= r_arm_cnt + 2'd1;
      end
      r_cclk_prev <= w_cclk_s;
      r_load_prev <= w_load_s;
      r_sel_prev  <= w_sel_s;
      r_chain_0   <= w_chain_0_d;
      r_chain_1   <= w_chain_1_d;
      r_cfg_q_0   <= w_cfg_q_0_d;
      r_cfg_q_1   <= w_cfg_q_1_d;
      r_shift_cnt <= w_shift_cnt_d;
      r_len_err   <= w_len_err_d;
      r_cfg_out   <= w_hold ? 1'b0 :
                     (w_sel_s ? r_chain_1[CFG_BITS-1] : r_chain_0[CFG_BITS-1]);
    end
  end

  assign fw_config_out = r_cfg_out;
  assign cfg_q_0       = r_cfg_q_0;
  assign cfg_q_1       = r_cfg_q_1;
  assign shift_cnt     = r_shift_cnt;
  assign load_strobe   = (r_state == StLoading);
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_cms_pix_28_dut_cfg_emu.sv
// Randomized bench for the configuration-chain emulator with a queue-based load scoreboard.
module tb_cms_pix_28_dut_cfg_emu;

  localparam int CB = 64;

  logic          fw_clk = 1'b0;
  logic          fw_rst;
  logic          fw_super_pixel_sel;
  logic          fw_config_clk;
  logic          fw_reset_not;
  logic          fw_config_in;
  logic          fw_config_load;
  logic          fw_config_out;
  logic [CB-1:0] cfg_q_0;
  logic [CB-1:0] cfg_q_1;
  logic [15:0]   shift_cnt;
  logic          load_strobe;
  logic          len_err;

  cms_pix_28_dut_cfg_emu #(
    .CFG_BITS (CB)
  ) dut (
    .fw_clk             (fw_clk),
    .fw_rst             (fw_rst),
    .fw_super_pixel_sel (fw_super_pixel_sel),
    .fw_config_clk      (fw_config_clk),
    .fw_reset_not       (fw_reset_not),
    .fw_config_in       (fw_config_in),
    .fw_config_load     (fw_config_load),
    .fw_config_out      (fw_config_out),
    .cfg_q_0            (cfg_q_0),
    .cfg_q_1            (cfg_q_1),
    .shift_cnt          (shift_cnt),
    .load_strobe        (load_strobe),
    .len_err            (len_err)
  );

  always #5 fw_clk = ~fw_clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: two 64-bit chains fed MSB-first, latched copies, a shift counter.
  typedef struct {
    logic [63:0] q0;
    logic [63:0] q1;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_chain[2];
  logic [63:0] m_q[2];
  logic        m_err;
  int          m_cnt;
  int          m_sel;

  task automatic m_clear();
    m_chain[0] = '0; m_chain[1] = '0;
    m_q[0] = '0; m_q[1] = '0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic m_shift(input logic b);
    m_chain[m_sel] = (m_chain[m_sel] << 1) | 64'(b);
    if (m_cnt < 65535) m_cnt++;
  endtask

  task automatic m_load();
    exp_t e;
    m_q[m_sel] = m_chain[m_sel];
    if (m_cnt != CB) m_err = 1'b1;
    m_cnt = 0;
    e.q0 = m_q[0]; e.q1 = m_q[1]; e.err = m_err;
    exp_q.push_back(e);
  endtask

  function automatic logic m_out();
    return m_chain[m_sel][63];
  endfunction

  // Monitor: every load_strobe pops one expected load result.
  logic prev_strobe = 1'b0;
  always @(negedge fw_clk) begin
    exp_t e;
    if (prev_strobe) chk("strobe_width", load_strobe, 1'b0);
    if (load_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: got strobe expected none");
      end else begin
        e = exp_q.pop_front();
        chk("load_cfg_q_0", cfg_q_0, e.q0);
        chk("load_cfg_q_1", cfg_q_1, e.q1);
        chk("load_len_err", len_err, e.err);
        chk("load_shift_cnt", shift_cnt, 0);
      end
    end
    prev_strobe <= (load_strobe === 1'b1);
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_cfg_out"}, fw_config_out, 0);
    chk({pfx, "_cfg_q_0"}, cfg_q_0, 0);
    chk({pfx, "_cfg_q_1"}, cfg_q_1, 0);
    chk({pfx, "_shift_cnt"}, shift_cnt, 0);
    chk({pfx, "_strobe"}, load_strobe, 0);
    chk({pfx, "_len_err"}, len_err, 0);
  endtask

  task automatic shift_bit(input logic b, input bit chk_out);
    logic old;
    @(posedge fw_clk); #1;
    fw_config_in  = b;
    fw_config_clk = 1'b1;
    old = m_out();
    m_shift(b);
    if (chk_out) begin
      repeat (3) @(posedge fw_clk);
      @(negedge fw_clk);
      chk("cfg_out_early", fw_config_out, old);
      @(posedge fw_clk);
      @(negedge fw_clk);
      chk("cfg_out_replay", fw_config_out, m_out());
    end else begin
      repeat (3) @(posedge fw_clk);
    end
    @(posedge fw_clk); #1;
    fw_config_clk = 1'b0;
    repeat (3) @(posedge fw_clk);
  endtask

  task automatic shift_word(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) shift_bit(d[i], 1'b0);
  endtask

  task automatic do_load();
    @(posedge fw_clk); #1;
    fw_config_load = 1'b1;
    m_load();
    repeat (4) @(posedge fw_clk); #1;
    fw_config_load = 1'b0;
    repeat (4) @(posedge fw_clk);
    @(negedge fw_clk);
    chk("len_err", len_err, m_err);
  endtask

  task automatic set_sel(input int s);
    @(posedge fw_clk); #1;
    fw_super_pixel_sel = s[0];
    if (s != m_sel) begin
      if (m_cnt != 0 && m_cnt != CB) m_err = 1'b1;
      m_cnt = 0;
      m_sel = s;
    end
    repeat (4) @(posedge fw_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d;
    fw_rst = 1'b1;
    fw_super_pixel_sel = 1'b0;
    fw_config_clk = 1'b0;
    fw_reset_not = 1'b1;
    fw_config_in = 1'b0;
    fw_config_load = 1'b0;
    m_sel = 0;
    m_clear();
    repeat (3) @(posedge fw_clk);
    #1;
    chk_zero("in_rst");
    fw_rst = 1'b0;
    repeat (8) @(posedge fw_clk);
    @(negedge fw_clk);
    chk_zero("post_rst");

    // Fixed pattern on chain 0
    set_sel(0);
    shift_word(64'hA5A5_0F0F_1234_5678);
    @(negedge fw_clk);
    chk("shift_cnt_full", shift_cnt, m_cnt);
    do_load();
    chk("cfg_q_0_fixed", cfg_q_0, 64'hA5A5_0F0F_1234_5678);

    // 64th shift coincides with the load
    d = {$urandom, $urandom};
    for (int i = 63; i >= 1; i--) shift_bit(d[i], 1'b0);
    @(posedge fw_clk); #1;
    fw_config_in = d[0];
    fw_config_clk = 1'b1;
    fw_config_load = 1'b1;
    m_shift(d[0]);
    m_load();
    repeat (4) @(posedge fw_clk); #1;
    fw_config_clk = 1'b0;
    fw_config_load = 1'b0;
    repeat (4) @(posedge fw_clk);
    @(negedge fw_clk);
    chk("same_cycle_len_err", len_err, 1'b0);

    // Load a random word then shift zeros; the loaded word replays MSB-first
    d = {$urandom, $urandom};
    shift_word(d);
    do_load();
    @(negedge fw_clk);
    chk("replay_first", fw_config_out, d[63]);
    for (int i = 0; i < CB; i++) shift_bit(1'b0, 1'b1);
    @(negedge fw_clk);
    chk("shift_cnt_replay", shift_cnt, m_cnt);

    // Chain 1 overshifted by one bit
    set_sel(1);
    @(negedge fw_clk);
    chk("sel_chg_cnt", shift_cnt, 0);
    chk("sel_chg_err", len_err, m_err);
    shift_bit(1'($urandom_range(0, 1)), 1'b0);
    d = {$urandom, $urandom};
    shift_word(d);
    @(negedge fw_clk);
    chk("shift_cnt_65", shift_cnt, m_cnt);
    do_load();
    chk("overshift_err", len_err, 1'b1);

    // DUT-side hold mid-shift with a config_clk rise during it
    for (int i = 0; i < 20; i++) shift_bit(1'($urandom_range(0, 1)), 1'b0);
    @(posedge fw_clk); #1;
    fw_reset_not = 1'b0;
    fw_config_clk = 1'b1;
    fw_config_in = 1'b1;
    repeat (3) @(posedge fw_clk); #1;
    fw_reset_not = 1'b1;
    @(posedge fw_clk);
    @(negedge fw_clk);
    chk_zero("hold");
    m_clear();
    repeat (8) @(posedge fw_clk); #1;
    fw_config_clk = 1'b0;
    repeat (4) @(posedge fw_clk);
    @(negedge fw_clk);
    chk("hold_no_shift", shift_cnt, 0);
    d = {$urandom, $urandom};
    shift_word(d);
    do_load();

    // Asynchronous reset with shift and load edges in flight
    for (int i = 0; i < 10; i++) shift_bit(1'($urandom_range(0, 1)), 1'b0);
    @(posedge fw_clk); #1;
    fw_config_clk = 1'b1;
    fw_config_load = 1'b1;
    fw_config_in = 1'b1;
    @(posedge fw_clk); #3;
    fw_rst = 1'b1;
    #1;
    chk_zero("async_rst");
    m_clear();
    repeat (3) @(posedge fw_clk); #1;
    fw_rst = 1'b0;
    repeat (10) @(posedge fw_clk);
    @(negedge fw_clk);
    chk("rst_release_cnt", shift_cnt, 0);
    chk("rst_release_q1", cfg_q_1, 0);
    @(posedge fw_clk); #1;
    fw_config_clk = 1'b0;
    fw_config_load = 1'b0;
    repeat (4) @(posedge fw_clk);
    @(negedge fw_clk);
    chk("rst_release_cnt2", shift_cnt, 0);
    d = {$urandom, $urandom};
    shift_word(d);
    do_load();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge fw_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
